// File: rtl/mac_driver.sv
//==============================================================================
// mac_driver : sequences one MAC dot-product (clear, feed len pairs, capture)
// and offers the captured 8-bit result on a valid/ready handshake.
// Revision: 1.0
//==============================================================================
`default_nettype none

module mac_driver #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] win_addr_o,
  input  logic [7:0]        win_data_i,
  output logic [ADDR_W-1:0] fil_addr_o,
  input  logic [7:0]        fil_data_i,
  output logic              mac_clean_reg_o,
  output logic              mac_reg_en_o,
  output logic [7:0]        mac_window_o,
  output logic [7:0]        mac_filter_o,
  input  logic [7:0]        mac_result_i,
  output logic              out_valid_o,
  output logic [7:0]        out_data_o,
  input  logic              out_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_FEED    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        out_data_q, out_data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      addr_q     <= '0;
      out_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    addr_d          = addr_q;
    out_data_d      = out_data_q;
    mac_clean_reg_o = 1'b0;
    mac_reg_en_o    = 1'b0;
    out_valid_o     = 1'b0;
    win_addr_o      = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d   = len_i;
          addr_d  = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        mac_clean_reg_o = 1'b1;
        win_addr_o      = addr_q;
        addr_d          = addr_q + 1'b1;
        state_d         = (len_q != '0) ? S_FEED : S_CAPTURE;
      end
      S_FEED: begin
        // addr_q runs one ahead of the pair being consumed, so the pair
        // for index len_q-1 is on the operands when addr_q reaches len_q.
        mac_reg_en_o = 1'b1;
        win_addr_o   = addr_q;
        addr_d       = addr_q + 1'b1;
        if (addr_q == len_q) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        out_data_d = mac_result_i;
        state_d    = S_DONE;
      end
      S_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o       = (state_q != S_IDLE);
  assign fil_addr_o   = win_addr_o;
  assign mac_window_o = win_data_i;
  assign mac_filter_o = fil_data_i;
  assign out_data_o   = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_driver.sv
//==============================================================================
// tb_mac_driver : randomized bench with buffer/MAC environment and a
// transaction-level reference model of the expected cycle behaviour.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_mac_driver;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] len;
  logic              busy;
  logic [ADDR_W-1:0] win_addr, fil_addr;
  logic [7:0]        win_data, fil_data;
  logic              mac_clean, mac_en;
  logic [7:0]        mac_window, mac_filter, mac_result;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_driver #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .len_i          (len),
    .busy_o         (busy),
    .win_addr_o     (win_addr),
    .win_data_i     (win_data),
    .fil_addr_o     (fil_addr),
    .fil_data_i     (fil_data),
    .mac_clean_reg_o(mac_clean),
    .mac_reg_en_o   (mac_en),
    .mac_window_o   (mac_window),
    .mac_filter_o   (mac_filter),
    .mac_result_i   (mac_result),
    .out_valid_o    (out_valid),
    .out_data_o     (out_data),
    .out_ready_i    (out_ready)
  );

  // Environment: synchronous-read buffers and a MAC with a 12-bit accumulator.
  logic [7:0]  wbuf [16];
  logic [7:0]  fbuf [16];
  logic [11:0] acc;

  always @(posedge clk) begin
    win_data <= wbuf[win_addr];
    fil_data <= fbuf[fil_addr];
  end

  always @(posedge clk or posedge rst) begin
    if (rst)            acc <= 12'h000;
    else if (mac_clean) acc <= 12'h000;
    else if (mac_en)    acc <= acc + 12'(({8'h00, mac_window} * {8'h00, mac_filter}) >> 8);
  end
  assign mac_result = acc[11:4];

  function automatic logic [7:0] ref_result(input int n);
    logic [11:0] a;
    int p;
    a = 12'h000;
    for (int i = 0; i < n; i++) begin
      p = {24'h0, wbuf[i]} * {24'h0, fbuf[i]};
      a = a + 12'(p >> 8);
    end
    return a[11:4];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle index c within the current run (1 = CLEAR).
  bit         active;
  int         c, mlen;
  logic [7:0] exp_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      active = 1'b0;
      c      = 0;
    end else if (!active) begin
      if (start) begin
        active  = 1'b1;
        c       = 1;
        mlen    = int'(len);
        exp_res = ref_result(int'(len));
      end
    end else if (c >= mlen + 3 && out_ready) begin
      active = 1'b0;
    end else begin
      c++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy",     32'(busy),      32'(active));
      chk("clean",    32'(mac_clean), 32'(active && c == 1));
      chk("reg_en",   32'(mac_en),    32'(active && c >= 2 && c <= mlen + 1));
      chk("valid",    32'(out_valid), 32'(active && c >= mlen + 3));
      chk("fil_addr", 32'(fil_addr),  32'(win_addr));
      chk("win_pass", 32'(mac_window), 32'(win_data));
      chk("fil_pass", 32'(mac_filter), 32'(fil_data));
      if (active && c == 1)
        chk("addr_clear", 32'(win_addr), 32'd0);
      if (active && c >= 2 && c <= mlen)
        chk("addr_feed", 32'(win_addr), 32'(c - 1));
      if (active && c >= 2 && c <= mlen + 1) begin
        chk("op_win", 32'(mac_window), 32'(wbuf[c-2]));
        chk("op_fil", 32'(mac_filter), 32'(fbuf[c-2]));
      end
      if (active && c >= mlen + 3)
        chk("out_data", 32'(out_data), 32'(exp_res));
    end
  end

  task automatic fill(input int mode, input logic [7:0] v);
    for (int i = 0; i < 16; i++) begin
      wbuf[i] = (mode == 0) ? v : 8'($urandom);
      fbuf[i] = (mode == 0) ? v : 8'($urandom);
    end
  endtask

  // Entered at posedge+1; leaves at posedge+1 of the first IDLE cycle.
  task automatic run(input int l, input int hold, input bit poke, output logic [7:0] got);
    int cyc;
    start = 1'b1;
    len   = ADDR_W'(l);
    @(posedge clk); #1;
    start = 1'b0;
    len   = ADDR_W'($urandom);
    cyc   = 1;
    while (!out_valid && cyc < 64) begin
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(l + 3));
    got = out_data;
    chk("result", 32'(got), 32'(ref_result(l)));
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start     = poke;
      @(posedge clk); #1;
      chk("hold_data", 32'(out_data), 32'(got));
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [7:0] r;

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; out_ready = 1'b0;
    fill(0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_en",    32'(mac_en),    32'd0);
    chk("rst_clean", 32'(mac_clean), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_addr",  32'(win_addr),  32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    fill(0, 8'h80);
    run(3, 0, 1'b0, r);
    chk("basic_lit", 32'(r), 32'h0C);
    @(posedge clk); #1;
    run(0, 0, 1'b0, r);
    chk("zero_lit", 32'(r), 32'h00);
    @(posedge clk); #1;
    fill(0, 8'hFF);
    run(15, 0, 1'b0, r);
    chk("max_lit", 32'(r), 32'hEE);
    @(posedge clk); #1;
    fill(1, 8'h00);
    run(6, 5, 1'b1, r);
    fill(1, 8'h00);
    run(5, 0, 1'b0, r);
    run(4, 0, 1'b0, r);

    // Reset during the second FEED cycle of a len=8 run.
    fill(1, 8'h00);
    start = 1'b1; len = 4'd8;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_en", 32'(mac_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy",  32'(busy),      32'd0);
    chk("mid_rst_en",    32'(mac_en),    32'd0);
    chk("mid_rst_clean", 32'(mac_clean), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_addr",  32'(win_addr),  32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    fill(1, 8'h00);
    run(2, 0, 1'b0, r);

    for (int k = 0; k < 25; k++) begin
      fill(1, 8'h00);
      run(int'($urandom_range(0, 15)), int'($urandom_range(0, 4)), 1'($urandom), r);
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mac_driver.md
# mac_driver

Sequencer that drives one MAC datapath through a single dot-product. On `start` it clears the MAC accumulator, then reads `len` window/filter byte pairs from two synchronous-read buffers and presents them to the MAC, one pair per cycle with the accumulate enable asserted. It then captures the MAC's 8-bit result and offers it downstream on a valid/ready handshake. It sits between the window/filter buffers and the MAC inside each processing element: it is the initiator side of the MAC's `reg_en`/`clean_reg`/operand interface.

## Interface
- `ADDR_W`, 4: buffer address width. Maximum `len` is 2^ADDR_W − 1.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request one dot-product; sampled only in IDLE.
- `len`  in  ADDR_W  number of products; sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `win_addr`  out  ADDR_W  window buffer read address.
- `win_data`  in  8  window buffer data, valid one cycle after `win_addr`.
- `fil_addr`  out  ADDR_W  filter buffer read address, always equal to `win_addr`.
- `fil_data`  in  8  filter buffer data, valid one cycle after `fil_addr`.
- `mac_clean_reg`  out  1  clears the MAC accumulator.
- `mac_reg_en`  out  1  accumulate enable.
- `mac_window`  out  8  MAC operand; combinational pass-through of `win_data`.
- `mac_filter`  out  8  MAC operand; combinational pass-through of `fil_data`.
- `mac_result`  in  8  MAC result (accumulator bits [11:4]).
- `out_valid`  out  1  captured result available.
- `out_data`  out  8  captured result.
- `out_ready`  in  1  downstream accepts `out_data`.

## Operation
- States: IDLE, CLEAR, FEED, CAPTURE, DONE.
- IDLE: if `start`=1, latch `len` into `len_q`, clear the index counter, and go to CLEAR.
- CLEAR (1 cycle):
  - `mac_clean_reg`=1 and `win_addr`=`fil_addr`=0.
  - Go to FEED if `len_q`≠0, else go to CAPTURE.
- FEED (exactly `len_q` cycles):
  - `mac_reg_en`=1; operands are the buffer data for the address issued in the previous cycle.
  - Each cycle the address is incremented; the next address is issued while the current pair is consumed.
  - Leave FEED after the cycle that consumes index `len_q`−1. The out-of-range address issued in that cycle is don't-care.
- CAPTURE (1 cycle): `out_data` ← `mac_result`, which by now reflects every accumulation. Go to DONE.
- DONE: `out_valid`=1 and `out_data` is held stable. When `out_ready`=1, go to IDLE.
- `mac_reg_en` and `mac_clean_reg` are never high in the same cycle, and both are 0 outside CLEAR and FEED respectively.
- `len`=0: the accumulator is still cleared, so the result is 0x00.
- The MAC's accumulator width, truncation and overflow behaviour belong to the MAC. This block adds no arithmetic.

## Timing
- Reset values: state IDLE; `busy`, `out_valid`, `mac_reg_en` and `mac_clean_reg` all 0; `out_data`=0x00; `win_addr`=`fil_addr`=0.
- Cycle numbering: cycle 0 is the IDLE cycle in which `start` is sampled.
- Cycle 1: CLEAR.
- Cycles 2 … `len`+1: FEED.
- Cycle `len`+2: CAPTURE.
- Cycle `len`+3: first cycle with `out_valid`=1. With `len`=0 this is cycle 3.
- Latency from `start` to `out_valid` is `len`+3 cycles.
- `out_ready` high in the first DONE cycle gives a one-cycle `out_valid` pulse. IDLE follows, and the next `start` can be accepted one cycle later.
- `out_ready` while not in DONE: ignored.
- `start` while `busy`=1: ignored. `len` changes while busy: ignored.
- Reset mid-operation: outputs return to reset values immediately, asynchronously. A partial result is never presented. The MAC shares `rst`, so its accumulator is cleared as well.
- `busy` goes high in the cycle after `start` is sampled and goes low in the cycle after the DONE handshake.

## Test plan
- Basic dot-product:
  - Stimulus: `len`=3; window buffer = 0x80, 0x80, 0x80; filter buffer = 0x80, 0x80, 0x80.
  - Response: `mac_clean_reg` high in cycle 1; `mac_reg_en` high in cycles 2–4 with operands 0x80/0x80; `out_valid` first high in cycle 6 with `out_data`=0x0C.
- Zero length: `len`=0 → no `mac_reg_en` pulse; `out_valid` in cycle 3 with `out_data`=0x00.
- Maximum length:
  - Stimulus: `len`=15; all window and filter entries = 0xFF.
  - Response: addresses 0–14 issued in order; exactly 15 `mac_reg_en` cycles; `out_data` equals a behavioural MAC model result (acc += (w·f)>>8; result = acc[11:4]).
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out_valid`=1 and `out_data` stable throughout; a `start` pulse applied during DONE is ignored.
- Back-to-back: assert `out_ready` in the first DONE cycle and `start` in the following IDLE cycle → the second run starts correctly, and `mac_clean_reg` fires again before any accumulation.
- Reset mid-FEED: assert `rst` in cycle 3 of a `len`=8 run → all outputs 0 that cycle; after release, a new run with `len`=2 gives the correct model result.
